// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    // Default operand / result width in bits.
    localparam int DIV_WIDTH_DEFAULT = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negation: takes the magnitude of a negative
// operand, or applies the sign correction to an unsigned result.
module div_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    // Negate when enabled; report the raw sign bit of the input.
    always_comb begin
        sign = value[WIDTH-1];
        if (en) begin
            magnitude = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = value;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or
// unsigned operands, truncating toward zero, divide-by-zero flagged.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH_DEFAULT,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done_division,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
    localparam logic           SIGNED_HW = (SIGNED_EN != 0);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] bmag_q, bmag_d;     // divisor magnitude
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;

    logic             sgn_s, a_sign_s, b_sign_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] rem_src_s, q_fix_s, r_fix_s;
    logic             q_fix_sign_s, r_fix_sign_s;
    logic             div_unused_s;

    assign sgn_s   = SIGNED_HW & signed_mode;
    assign a_neg_s = sgn_s & a_sign_s;
    assign b_neg_s = sgn_s & b_sign_s;

    div_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value(a), .en(a_neg_s), .magnitude(a_mag_s), .sign(a_sign_s)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value(b), .en(b_neg_s), .magnitude(b_mag_s), .sign(b_sign_s)
    );

    // On divide-by-zero the untouched dividend magnitude becomes the remainder.
    assign rem_src_s = dz_pend_q ? dvd_q : rem_q[WIDTH-1:0];

    div_abs #(.WIDTH(WIDTH)) u_fix_q (
        .value(dvd_q), .en(quo_neg_q), .magnitude(q_fix_s), .sign(q_fix_sign_s)
    );

    div_abs #(.WIDTH(WIDTH)) u_fix_r (
        .value(rem_src_s), .en(rem_neg_q), .magnitude(r_fix_s), .sign(r_fix_sign_s)
    );

    // Remainder MSB is always zero after a restore step; fix-up signs are not needed.
    assign div_unused_s = ^{rem_q[WIDTH], q_fix_sign_s, r_fix_sign_s};

    // Restoring step: shift in the next dividend bit and try subtracting the divisor.
    assign shifted_s = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign trial_s   = {1'b0, shifted_s} - {2'b00, bmag_q};

    // Next-state, datapath and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        bmag_d    = bmag_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_pend_d = dz_pend_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = {CW{1'b0}};
                    rem_d     = {(WIDTH+1){1'b0}};
                    dvd_d     = a_mag_s;
                    bmag_d    = b_mag_s;
                    quo_neg_d = a_neg_s ^ b_neg_s;
                    rem_neg_d = a_neg_s;
                    dz_pend_d = (b == {WIDTH{1'b0}});
                    state_d   = (b == {WIDTH{1'b0}}) ? FIX : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (trial_s[WIDTH+1]) begin
                    rem_d = shifted_s;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial_s[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                q_d     = dz_pend_q ? {WIDTH{1'b1}} : q_fix_s;
                r_d     = r_fix_s;
                dz_d    = dz_pend_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {(WIDTH+1){1'b0}};
            dvd_q     <= {WIDTH{1'b0}};
            bmag_q    <= {WIDTH{1'b0}};
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_pend_q <= 1'b0;
            q_q       <= {WIDTH{1'b0}};
            r_q       <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            bmag_q    <= bmag_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_pend_q <= dz_pend_d;
            q_q       <= q_d;
            r_q       <= r_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            dz_q      <= dz_d;
        end
    end

    assign q             = q_q;
    assign r             = r_q;
    assign done_division = done_q;
    assign busy          = busy_q;
    assign div_by_zero   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider at WIDTH=4.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       done_division;
    logic       busy;
    logic       div_by_zero;

    int total;
    int bad;

    typedef struct {
        string      name;
        logic       sgn;
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] eq;
        logic [3:0] er;
        logic       edz;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    seq_divider #(.WIDTH(4), .SIGNED_EN(1)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_mode(signed_mode),
        .a(a),
        .b(b),
        .q(q),
        .r(r),
        .done_division(done_division),
        .busy(busy),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one division and return the edge count (accepting edge = 1) at which done is seen.
    task automatic run_div(input logic s, input logic [3:0] av, input logic [3:0] bv, output int lat);
        @(negedge clk);
        signed_mode = s;
        a = av;
        b = bv;
        start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) check("busy_after_accept", int'(busy), 1);
            if (done_division) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first;
        int second;
        int cyc;
        logic [3:0] hq;
        logic [3:0] hr;

        total = 0;
        bad = 0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = 4'd0;
        b = 4'd0;

        //          name          sgn   a      b      q      r      dz    lat
        vecs[0]  = '{"u4_2",      1'b0, 4'd4,  4'd2,  4'd2,  4'd0,  1'b0, 6};
        vecs[1]  = '{"u0_2",      1'b0, 4'd0,  4'd2,  4'd0,  4'd0,  1'b0, 6};
        vecs[2]  = '{"u9_2",      1'b0, 4'd9,  4'd2,  4'd4,  4'd1,  1'b0, 6};
        vecs[3]  = '{"u3_6",      1'b0, 4'd3,  4'd6,  4'd0,  4'd3,  1'b0, 6};
        vecs[4]  = '{"u7_0",      1'b0, 4'd7,  4'd0,  4'hF,  4'd7,  1'b1, 2};
        vecs[5]  = '{"u8_3",      1'b0, 4'd8,  4'd3,  4'd2,  4'd2,  1'b0, 6};
        vecs[6]  = '{"sm7_2",     1'b1, 4'h9,  4'h2,  4'hD,  4'hF,  1'b0, 6};
        vecs[7]  = '{"sm8_m1",    1'b1, 4'h8,  4'hF,  4'h8,  4'h0,  1'b0, 6};
        vecs[8]  = '{"u15_1",     1'b0, 4'hF,  4'h1,  4'hF,  4'h0,  1'b0, 6};
        vecs[9]  = '{"s7_m2",     1'b1, 4'h7,  4'hE,  4'hD,  4'h1,  1'b0, 6};
        vecs[10] = '{"sm1_0",     1'b1, 4'hF,  4'h0,  4'hF,  4'hF,  1'b1, 2};
        vecs[11] = '{"u8_15",     1'b0, 4'h8,  4'hF,  4'h0,  4'h8,  1'b0, 6};

        // Reset state: outputs cleared asynchronously.
        rst = 1'b0;
        #1;
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
        check("rst_done", int'(done_division), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table of single operations.
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].sgn, vecs[i].av, vecs[i].bv, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_q"}, int'(q), int'(vecs[i].eq));
            check({vecs[i].name, "_r"}, int'(r), int'(vecs[i].er));
            check({vecs[i].name, "_dz"}, int'(div_by_zero), int'(vecs[i].edz));
            @(negedge clk);
            check({vecs[i].name, "_pulse1"}, int'(done_division), 0);
            check({vecs[i].name, "_hold_q"}, int'(q), int'(vecs[i].eq));
            check({vecs[i].name, "_idle"}, int'(busy), 0);
        end

        // Start and operand changes while busy are ignored.
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'd9;
        b = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'hF;
        b = 4'h1;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'd3;
        b = 4'd0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_division) pulses++;
        end
        check("busy_ign_pulses", pulses, 1);
        check("busy_ign_q", int'(q), 4);
        check("busy_ign_r", int'(r), 1);
        check("busy_ign_dz", int'(div_by_zero), 0);

        // Reset two cycles into CALC aborts the operation.
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'd9;
        b = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_q", int'(q), 0);
        check("midrst_r", int'(r), 0);
        check("midrst_done", int'(done_division), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_division) pulses++;
        end
        check("midrst_nopulse", pulses, 0);
        run_div(1'b0, 4'd9, 4'd2, lat);
        check("after_rst_lat", lat, 6);
        check("after_rst_q", int'(q), 4);
        check("after_rst_r", int'(r), 1);

        // Start held high: back-to-back results every WIDTH+3 cycles.
        @(negedge clk);
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'd4;
        b = 4'd2;
        start = 1'b1;
        first = -1;
        second = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done_division) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        start = 1'b0;
        hq = q;
        hr = r;
        check("held_first", first, 6);
        check("held_period", second - first, 7);
        check("held_q", int'(hq), 2);
        check("held_r", int'(hr), 0);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("held_drain", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL declare parameter WIDTH, default 8, meaning the operand/result width in bits (legal range 2..32).
REQ-002 The module SHALL declare parameter SIGNED_EN, default 1, meaning signed mode hardware is present (0 = unsigned only; signed_mode is ignored).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 The module SHALL have port signed_mode, input, 1 bit: treat a and b as two's complement; sampled with start.
REQ-007 The module SHALL have port a, input, WIDTH bits: dividend; sampled with start.
REQ-008 The module SHALL have port b, input, WIDTH bits: divisor; sampled with start.
REQ-009 The module SHALL have port q, output, WIDTH bits: quotient, registered.
REQ-010 The module SHALL have port r, output, WIDTH bits: remainder, registered.
REQ-011 The module SHALL have port done_division, output, 1 bit: one-cycle pulse, q/r/div_by_zero valid.
REQ-012 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The module SHALL have port div_by_zero, output, 1 bit: registered flag, set for a division with b == 0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX, DONE with these transitions: IDLE -> CALC on start; CALC -> FIX after WIDTH iterations; FIX -> DONE; DONE -> IDLE unconditionally.
REQ-015 On an accepting edge (IDLE, start=1) the block SHALL latch the magnitudes of a/b (when signed), the result signs, and clear the partial remainder and the iteration counter.
REQ-016 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, with a (WIDTH+1)-bit partial remainder and a counter of width $clog2(WIDTH+1).
REQ-017 FIX SHALL apply sign correction and load q, r: quotient is negated when the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-018 done_division SHALL be high for exactly one cycle, in DONE, which is entered WIDTH+2 rising edges after the accepting edge.
REQ-019 q, r and div_by_zero SHALL hold their values from DONE until the FSM next enters DONE.
REQ-020 For b == 0, the FSM SHALL go IDLE -> FIX directly (CALC is skipped) and produce q = all ones, r = a, div_by_zero = 1, with done_division at edge 2 after acceptance.
REQ-021 In signed mode, a = most-negative and b = -1 SHALL yield q = most-negative, r = 0, div_by_zero = 0.
REQ-022 start asserted while busy SHALL be ignored; the in-flight operation and its latched operands SHALL be unaffected by changes on a, b or signed_mode.
REQ-023 A start held high across DONE SHALL be accepted on the first IDLE cycle after DONE; back-to-back throughput is one result per WIDTH+3 cycles.
REQ-024 A non-zero division with SIGNED_EN=0 or signed_mode=0 SHALL produce a unsigned-divided by b, and div_by_zero = 0.

Reset
REQ-025 When rst is low, the block SHALL asynchronously force state = IDLE, q = 0, r = 0, done_division = 0, busy = 0, div_by_zero = 0, and clear the counter and partial remainder.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no done_division pulse; the first start after rst deasserts SHALL be handled normally.

Structure
REQ-027 Package div_pkg SHALL hold the state enum (IDLE, CALC, FIX, DONE) and the default WIDTH constant.
REQ-028 The magnitude/negate logic SHALL live in a single sub-module div_abs (parameter WIDTH; in: value, en; out: magnitude, sign), instantiated for a, for b, and for the result fix-up.

Verification (WIDTH=4)
REQ-029 Unsigned 4/2, 0/2, 9/2, 3/6 SHALL give q/r = 2/0, 0/0, 4/1, 0/3, each with done_division exactly 6 edges after start.
REQ-030 7/0 SHALL give q = 4'hF, r = 7, div_by_zero = 1, done at edge 2; the next 8/3 SHALL give div_by_zero = 0, q = 2, r = 2.
REQ-031 Signed -7/2 (4'b1001/4'b0010) SHALL give q = 4'b1101 (-3), r = 4'b1111 (-1); signed -8/-1 SHALL give q = 4'b1000, r = 0.
REQ-032 start pulsed and a/b changed while busy SHALL leave the result of the original operands, with exactly one done_division pulse.
REQ-033 rst pulled low 2 cycles into CALC SHALL give all outputs 0 immediately and no done pulse; 9/2 afterwards SHALL give 4/1.
